// File: rtl/mnist_result_scorer.sv
// Purpose: two-stage scorer for binary MNIST outputs: per-class vote count, argmax, label compare, per-run accuracy counters.
// Latency: 2 enabled cycles from in_valid to out_valid; result_valid coincides with out_valid of the run's last sample.
// Backpressure: none; one sample per enabled cycle is accepted unconditionally, cke=0 freezes everything.
module mnist_result_scorer #(
  parameter int USER_WIDTH  = 8,
  parameter int CLASS_NUM   = 10,
  parameter int CHANNEL_NUM = 1,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cke,
  input  logic                            clear,
  input  logic                            in_last,
  input  logic [USER_WIDTH-1:0]           in_user,
  input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
  input  logic                            in_valid,
  output logic [$clog2(CLASS_NUM)-1:0]    out_index,
  output logic                            out_none,
  output logic                            out_match,
  output logic [USER_WIDTH-1:0]           out_user,
  output logic                            out_valid,
  output logic [COUNT_WIDTH-1:0]          result_total,
  output logic [COUNT_WIDTH-1:0]          result_ok,
  output logic                            result_valid
);

  localparam int INDEX_WIDTH = $clog2(CLASS_NUM);
  localparam int SCORE_WIDTH = $clog2(CHANNEL_NUM + 1);
  localparam int CMP_WIDTH   = (USER_WIDTH > INDEX_WIDTH) ? USER_WIDTH : INDEX_WIDTH;

  typedef logic [SCORE_WIDTH-1:0] score_t;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } meta_t;

  score_t [CLASS_NUM-1:0] score_nxt;
  score_t [CLASS_NUM-1:0] s1_score;
  meta_t                  s1_meta;

  score_t                 best_score;
  logic [INDEX_WIDTH-1:0] best_index;
  logic                   none_nxt;
  logic                   match_nxt;

  logic [COUNT_WIDTH-1:0] cnt_total;
  logic [COUNT_WIDTH-1:0] cnt_ok;
  logic [COUNT_WIDTH-1:0] total_inc;
  logic [COUNT_WIDTH-1:0] ok_inc;

  // Stage 1: count the votes each class received across all channels.
  always_comb begin
    score_nxt = '0;
    for (int i = 0; i < CLASS_NUM; i++) begin
      for (int j = 0; j < CHANNEL_NUM; j++) begin
        score_nxt[i] = score_nxt[i] + SCORE_WIDTH'(in_data[j*CLASS_NUM+i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_meta  <= '0;
      s1_score <= '0;
    end else if (cke) begin
      if (clear) begin
        s1_meta.valid <= 1'b0;
      end else begin
        s1_meta.valid <= in_valid;
        if (in_valid) begin
          s1_meta.last <= in_last;
          s1_meta.user <= in_user;
          s1_score     <= score_nxt;
        end
      end
    end
  end

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_score = '0;
    best_index = '0;
    for (int i = 0; i < CLASS_NUM; i++) begin
      if (s1_score[i] > best_score) begin
        best_score = s1_score[i];
        best_index = INDEX_WIDTH'(i);
      end
    end
    none_nxt  = (best_score == '0);
    match_nxt = !none_nxt && (CMP_WIDTH'(best_index) == CMP_WIDTH'(s1_meta.user));
  end

  // Saturating counter increments.
  always_comb begin
    total_inc = (&cnt_total) ? cnt_total : cnt_total + COUNT_WIDTH'(1);
    ok_inc    = (match_nxt && !(&cnt_ok)) ? cnt_ok + COUNT_WIDTH'(1) : cnt_ok;
  end

  // Stage 2: per-sample result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_index <= '0;
      out_none  <= 1'b0;
      out_match <= 1'b0;
      out_user  <= '0;
      out_valid <= 1'b0;
    end else if (cke) begin
      if (clear) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= s1_meta.valid;
        if (s1_meta.valid) begin
          out_index <= best_index;
          out_none  <= none_nxt;
          out_match <= match_nxt;
          out_user  <= s1_meta.user;
        end
      end
    end
  end

  // Run accounting: the last beat publishes totals that include itself and restarts the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_total    <= '0;
      cnt_ok       <= '0;
      result_total <= '0;
      result_ok    <= '0;
      result_valid <= 1'b0;
    end else if (cke) begin
      if (clear) begin
        cnt_total    <= '0;
        cnt_ok       <= '0;
        result_total <= '0;
        result_ok    <= '0;
        result_valid <= 1'b0;
      end else begin
        result_valid <= s1_meta.valid & s1_meta.last;
        if (s1_meta.valid) begin
          if (s1_meta.last) begin
            result_total <= total_inc;
            result_ok    <= ok_inc;
            cnt_total    <= '0;
            cnt_ok       <= '0;
          end else begin
            cnt_total <= total_inc;
            cnt_ok    <= ok_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mnist_result_scorer.sv
// Directed bench for mnist_result_scorer: vector tables for the datapath and run counters, hand sequences for cke, clear and reset.
module tb_mnist_result_scorer;

  logic clk = 1'b0;
  logic reset, cke, clear;

  logic        in_last, in_valid;
  logic [7:0]  in_user;
  logic [9:0]  in_data;
  logic [3:0]  out_index;
  logic        out_none, out_match, out_valid, result_valid;
  logic [7:0]  out_user;
  logic [31:0] result_total, result_ok;

  logic        in_last3, in_valid3;
  logic [7:0]  in_user3;
  logic [29:0] in_data3;
  logic [3:0]  out_index3;
  logic        out_none3, out_match3, out_valid3, result_valid3;
  logic [7:0]  out_user3;
  logic [31:0] result_total3, result_ok3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] data;
    logic [7:0]  user;
    logic        last;
    logic [3:0]  idx;
    logic        none;
    logic        match;
    logic [31:0] total;
    logic [31:0] ok;
  } vec_t;

  vec_t vecs[$];

  mnist_result_scorer u_dut (
    .clk(clk), .reset(reset), .cke(cke), .clear(clear),
    .in_last(in_last), .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
    .out_index(out_index), .out_none(out_none), .out_match(out_match), .out_user(out_user),
    .out_valid(out_valid), .result_total(result_total), .result_ok(result_ok),
    .result_valid(result_valid)
  );

  mnist_result_scorer #(.CHANNEL_NUM(3)) u_dut3 (
    .clk(clk), .reset(reset), .cke(cke), .clear(clear),
    .in_last(in_last3), .in_user(in_user3), .in_data(in_data3), .in_valid(in_valid3),
    .out_index(out_index3), .out_none(out_none3), .out_match(out_match3), .out_user(out_user3),
    .out_valid(out_valid3), .result_total(result_total3), .result_ok(result_ok3),
    .result_valid(result_valid3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit use3, input logic v, input logic [29:0] d,
                       input logic [7:0] u, input logic l);
    if (use3) begin
      in_valid3 = v; in_data3 = d; in_user3 = u; in_last3 = l;
    end else begin
      in_valid = v; in_data = d[9:0]; in_user = u; in_last = l;
    end
  endtask

  function automatic vec_t mk(input logic [29:0] d, input logic [7:0] u, input logic l,
                              input logic [3:0] idx, input logic none, input logic match,
                              input logic [31:0] tot, input logic [31:0] ok);
    vec_t v;
    v.data = d; v.user = u; v.last = l; v.idx = idx;
    v.none = none; v.match = match; v.total = tot; v.ok = ok;
    return v;
  endfunction

  // Streams vecs back-to-back; each beat's result is visible two negedges after it is driven.
  task automatic run_vectors(input bit use3);
    int n = vecs.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        vec_t e = vecs[k-2];
        chk($sformatf("v%0d_valid", k-2), 64'(use3 ? out_valid3 : out_valid), 64'd1);
        chk($sformatf("v%0d_index", k-2), 64'(use3 ? out_index3 : out_index), 64'(e.idx));
        chk($sformatf("v%0d_none", k-2), 64'(use3 ? out_none3 : out_none), 64'(e.none));
        chk($sformatf("v%0d_match", k-2), 64'(use3 ? out_match3 : out_match), 64'(e.match));
        chk($sformatf("v%0d_user", k-2), 64'(use3 ? out_user3 : out_user), 64'(e.user));
        chk($sformatf("v%0d_result_valid", k-2), 64'(use3 ? result_valid3 : result_valid), 64'(e.last));
        if (e.last) begin
          chk($sformatf("v%0d_total", k-2), 64'(use3 ? result_total3 : result_total), 64'(e.total));
          chk($sformatf("v%0d_ok", k-2), 64'(use3 ? result_ok3 : result_ok), 64'(e.ok));
        end
      end
      if (k < n) drive(use3, 1'b1, vecs[k].data, vecs[k].user, vecs[k].last);
      else       drive(use3, 1'b0, 30'd0, 8'd0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; cke = 1'b1; clear = 1'b0;
    drive(1'b0, 1'b0, 30'd0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 30'd0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_none", 64'(out_none), 64'd0);
    chk("rst_out_match", 64'(out_match), 64'd0);
    chk("rst_out_user", 64'(out_user), 64'd0);
    chk("rst_result_total", 64'(result_total), 64'd0);
    chk("rst_result_ok", 64'(result_ok), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    reset = 1'b1;

    // Default geometry: single-hot, empty, ties, out-of-range labels; run of 8 with 4 matches.
    vecs.delete();
    vecs.push_back(mk(30'h008, 8'd3,  1'b0, 4'd3, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h000, 8'd0,  1'b0, 4'd0, 1'b1, 1'b0, 32'd0, 32'd0));
    vecs.push_back(mk(30'h200, 8'd9,  1'b0, 4'd9, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h204, 8'd9,  1'b0, 4'd2, 1'b0, 1'b0, 32'd0, 32'd0));
    vecs.push_back(mk(30'h3FF, 8'd0,  1'b0, 4'd0, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h020, 8'd12, 1'b0, 4'd5, 1'b0, 1'b0, 32'd0, 32'd0));
    vecs.push_back(mk(30'h001, 8'd16, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0));
    vecs.push_back(mk(30'h080, 8'd7,  1'b1, 4'd7, 1'b0, 1'b1, 32'd8, 32'd4));
    run_vectors(1'b0);
    @(negedge clk);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_result_valid", 64'(result_valid), 64'd0);
    chk("hold_result_total", 64'(result_total), 64'd8);
    chk("hold_result_ok", 64'(result_ok), 64'd4);

    // Three channels: vote counting and tie handling.
    vecs.delete();
    vecs.push_back(mk(30'h0802_1004, 8'd7, 1'b0, 4'd2, 1'b0, 1'b0, 32'd0, 32'd0));
    vecs.push_back(mk(30'h0802_1084, 8'd7, 1'b0, 4'd7, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h0020_0200, 8'd1, 1'b0, 4'd1, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h0200_8008, 8'd5, 1'b0, 4'd5, 1'b0, 1'b1, 32'd0, 32'd0));
    run_vectors(1'b1);

    // Run of 5 with 3 correct, then a fresh 1-sample run.
    vecs.delete();
    vecs.push_back(mk(30'h001, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h002, 8'd2, 1'b0, 4'd1, 1'b0, 1'b0, 32'd0, 32'd0));
    vecs.push_back(mk(30'h010, 8'd4, 1'b0, 4'd4, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h040, 8'd6, 1'b0, 4'd6, 1'b0, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mk(30'h000, 8'd0, 1'b1, 4'd0, 1'b1, 1'b0, 32'd5, 32'd3));
    run_vectors(1'b0);
    vecs.delete();
    vecs.push_back(mk(30'h100, 8'd8, 1'b1, 4'd8, 1'b0, 1'b1, 32'd1, 32'd1));
    run_vectors(1'b0);

    // cke stall with a bogus beat offered while stalled.
    @(negedge clk); drive(1'b0, 1'b1, 30'h002, 8'd1, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 30'h004, 8'd2, 1'b1);
    @(negedge clk);
    chk("cke_pre_valid", 64'(out_valid), 64'd1);
    chk("cke_pre_index", 64'(out_index), 64'd1);
    cke = 1'b0;
    drive(1'b0, 1'b1, 30'h010, 8'd4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("cke_hold%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("cke_hold%0d_index", c), 64'(out_index), 64'd1);
      chk($sformatf("cke_hold%0d_result_valid", c), 64'(result_valid), 64'd0);
    end
    cke = 1'b1;
    drive(1'b0, 1'b0, 30'd0, 8'd0, 1'b0);
    @(negedge clk);
    chk("cke_post_valid", 64'(out_valid), 64'd1);
    chk("cke_post_index", 64'(out_index), 64'd2);
    chk("cke_post_result_valid", 64'(result_valid), 64'd1);
    chk("cke_post_total", 64'(result_total), 64'd2);
    chk("cke_post_ok", 64'(result_ok), 64'd2);
    @(negedge clk);
    chk("cke_end_valid", 64'(out_valid), 64'd0);
    chk("cke_end_result_valid", 64'(result_valid), 64'd0);

    // clear hits the last beat in stage 2, then a last beat at the input.
    drive(1'b0, 1'b1, 30'h008, 8'd3, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 30'h020, 8'd5, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 30'd0, 8'd0, 1'b0); clear = 1'b1;
    @(negedge clk);
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_result_valid", 64'(result_valid), 64'd0);
    chk("clr_result_total", 64'(result_total), 64'd0);
    chk("clr_result_ok", 64'(result_ok), 64'd0);
    drive(1'b0, 1'b1, 30'h040, 8'd6, 1'b1);
    @(negedge clk); clear = 1'b0; drive(1'b0, 1'b0, 30'd0, 8'd0, 1'b0);
    chk("clr_drop1_valid", 64'(out_valid), 64'd0);
    chk("clr_drop1_result_valid", 64'(result_valid), 64'd0);
    @(negedge clk);
    chk("clr_drop2_valid", 64'(out_valid), 64'd0);
    chk("clr_drop2_result_valid", 64'(result_valid), 64'd0);
    drive(1'b0, 1'b1, 30'h100, 8'd8, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 30'd0, 8'd0, 1'b0);
    @(negedge clk);
    chk("clr_run_valid", 64'(out_valid), 64'd1);
    chk("clr_run_result_valid", 64'(result_valid), 64'd1);
    chk("clr_run_total", 64'(result_total), 64'd1);
    chk("clr_run_ok", 64'(result_ok), 64'd1);

    // Asynchronous reset with two samples in flight.
    @(negedge clk); drive(1'b0, 1'b1, 30'h200, 8'd9, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 30'h002, 8'd1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 30'd0, 8'd0, 1'b0);
    chk("rst2_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_index", 64'(out_index), 64'd0);
    chk("rst2_out_user", 64'(out_user), 64'd0);
    chk("rst2_out_match", 64'(out_match), 64'd0);
    chk("rst2_result_total", 64'(result_total), 64'd0);
    chk("rst2_result_ok", 64'(result_ok), 64'd0);
    chk("rst2_result_valid", 64'(result_valid), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst2_flush_valid", 64'(out_valid), 64'd0);
    chk("rst2_flush_result_valid", 64'(result_valid), 64'd0);
    drive(1'b0, 1'b1, 30'h001, 8'd0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 30'd0, 8'd0, 1'b0);
    @(negedge clk);
    chk("rst2_run_valid", 64'(out_valid), 64'd1);
    chk("rst2_run_match", 64'(out_match), 64'd1);
    chk("rst2_run_result_valid", 64'(result_valid), 64'd1);
    chk("rst2_run_total", 64'(result_total), 64'd1);
    chk("rst2_run_ok", 64'(result_ok), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
